// File: rtl/word_unpacker_if.sv
// Handshake bundle for word_unpacker: word side from the FIFO, beat side to the consumer.
// parity_out is present only when WORD_UNPACKER_PARITY_EN is defined.
interface word_unpacker_if #(
    parameter int BYTES  = 4,
    parameter int BYTE_W = 8
);
    logic [BYTES*BYTE_W-1:0] data_in;
    logic                    valid_in;
    logic                    in_ready;
    logic [BYTE_W-1:0]       data_out;
    logic                    valid_out;
    logic                    out_ready;
    logic                    last_out;
`ifdef WORD_UNPACKER_PARITY_EN
    logic                    parity_out;

    // master is the surrounding FIFO/consumer pair, slave is the unpacker
    modport master (output data_in, valid_in, out_ready,
                    input  in_ready, data_out, valid_out, last_out, parity_out);
    modport slave  (input  data_in, valid_in, out_ready,
                    output in_ready, data_out, valid_out, last_out, parity_out);
`else
    modport master (output data_in, valid_in, out_ready,
                    input  in_ready, data_out, valid_out, last_out);
    modport slave  (input  data_in, valid_in, out_ready,
                    output in_ready, data_out, valid_out, last_out);
`endif
endinterface

// File: rtl/word_unpacker.sv
// Parallel-in/serial-out unpacker: one BYTES*BYTE_W word in, BYTES registered beats out.
// Optional registered even-parity output enabled by WORD_UNPACKER_PARITY_EN.
module word_unpacker #(
    parameter int BYTES     = 4,
    parameter int BYTE_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            rst,
    word_unpacker_if.slave  bus
);
    localparam int WORD_W = BYTES * BYTE_W;
    localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_nxt;
    logic [WORD_W-1:0]  shift_q, shift_nxt;
    logic [CNT_W-1:0]   count_q, count_nxt;
    logic [BYTE_W-1:0]  data_q, data_nxt;
    logic               valid_q, valid_nxt;
    logic               last_q, last_nxt;
    logic               beat_xfer;
    logic               in_ready;

    function automatic logic [BYTE_W-1:0] head(input logic [WORD_W-1:0] w);
        if (MSB_FIRST != 0)
            return w[WORD_W-1 -: BYTE_W];
        else
            return w[BYTE_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] drop(input logic [WORD_W-1:0] w);
        if (MSB_FIRST != 0)
            return w << BYTE_W;
        else
            return w >> BYTE_W;
    endfunction

    // Ready to take a word when empty or when the final beat leaves this cycle.
    assign beat_xfer = valid_q & bus.out_ready;
    assign in_ready  = rst & ((state == IDLE) | (beat_xfer & last_q));

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        count_nxt = count_q;
        data_nxt  = data_q;
        valid_nxt = valid_q;
        last_nxt  = last_q;
        case (state)
            IDLE: begin
                if (bus.valid_in) begin
                    state_nxt = SHIFT;
                    data_nxt  = head(bus.data_in);
                    shift_nxt = drop(bus.data_in);
                    count_nxt = '0;
                    valid_nxt = 1'b1;
                    last_nxt  = (BYTES == 1);
                end
            end
            SHIFT: begin
                if (beat_xfer && !last_q) begin
                    data_nxt  = head(shift_q);
                    shift_nxt = drop(shift_q);
                    count_nxt = count_q + 1'b1;
                    last_nxt  = (count_nxt == LAST_CNT);
                end else if (beat_xfer && bus.valid_in) begin
                    data_nxt  = head(bus.data_in);
                    shift_nxt = drop(bus.data_in);
                    count_nxt = '0;
                    valid_nxt = 1'b1;
                    last_nxt  = (BYTES == 1);
                end else if (beat_xfer) begin
                    state_nxt = IDLE;
                    data_nxt  = '0;
                    shift_nxt = '0;
                    count_nxt = '0;
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            count_q <= count_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            last_q  <= last_nxt;
        end
    end

`ifdef WORD_UNPACKER_PARITY_EN
    logic parity_q;

    // Parity tracks the next beat so it lands in the same cycle as data_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            parity_q <= 1'b0;
        else
            parity_q <= ^data_nxt;
    end

    assign bus.parity_out = parity_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.last_out  = last_q;
endmodule

// File: doc/word_unpacker.md
Name: word_unpacker

Overview:
- Parallel-in/serial-out unpacker: accepts one BYTES*BYTE_W-bit word per handshake and emits it as BYTES consecutive BYTE_W-bit beats.
- Inverse of the 8-to-32 SIPO shift register. Sits on the read side of the word FIFO and feeds a byte-wide consumer.
- Uses a valid/ready handshake on both sides, with full back-pressure and zero-bubble back-to-back words.

Parameters:
- BYTES, 4, beats per word (>=1).
- BYTE_W, 8, width of one beat in bits.
- MSB_FIRST, 1, 1: emit the most significant byte first; 0: emit the least significant byte first.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- data_in  input  BYTES*BYTE_W  word from the FIFO.
- valid_in  input  1  data_in is valid.
- in_ready  output  1  unpacker can accept a word this cycle.
- data_out  output  BYTE_W  current beat, registered.
- valid_out  output  1  data_out is valid.
- out_ready  input  1  consumer accepts the beat this cycle.
- last_out  output  1  data_out is the final beat of its word.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - state=IDLE, shift register=0, beat count=0.
  - data_out=0, valid_out=0, last_out=0.
  - in_ready=0 while rst=0.
- States:
  - IDLE: no word held.
  - SHIFT: word loaded, beats pending.
- in_ready (combinational from registers) = (state==IDLE) OR (valid_out AND out_ready AND last_out). It never depends on valid_in.
- Accept: valid_in AND in_ready at a rising edge:
  - Load the word.
  - data_out = first beat (MSB_FIRST=1: data_in[top BYTE_W bits]; 0: data_in[BYTE_W-1:0]).
  - valid_out=1, count=0, last_out=(BYTES==1), state=SHIFT.
  - Latency: the first beat is visible 1 cycle after the accepting edge.
- Beat transfer: valid_out AND out_ready at an edge:
  - If not last: count+1, data_out = next beat in order, last_out=1 when the new count==BYTES-1.
  - If last and valid_in: load the new word as in Accept, with no idle cycle (BYTES*N beats in BYTES*N cycles under continuous ready).
  - If last and not valid_in: state=IDLE, valid_out=0, last_out=0, data_out=0.
- Stall: valid_out=1 and out_ready=0:
  - data_out, last_out and count hold.
  - valid_out must not drop until the beat transfers.
- valid_in in SHIFT outside the last-beat transfer is ignored (in_ready=0). The FIFO holds the word.
- Count width is clog2(BYTES), min 1. The count never exceeds BYTES-1 and does not wrap within a word.
- Reset mid-word: the word in flight is discarded. All outputs take reset values immediately (asynchronously).
- No combinational path from valid_in to any output, or from out_ready to data_out/valid_out. The only combinational path is out_ready -> in_ready.

Optional Feature:
- Macro: WORD_UNPACKER_PARITY_EN.
- Defined:
  - Adds output port parity_out, width 1, registered alongside data_out.
  - parity_out = even parity (XOR reduction) of the beat on data_out.
  - parity_out is 0 at reset and in IDLE, and holds during a stall.
- Not defined: the port is absent and there is no parity logic. All other behaviour is identical.

Test Plan:
- Reset: rst=0 mid-simulation without a clock edge -> data_out=0, valid_out=0, last_out=0, in_ready=0. Release -> in_ready=1 with state IDLE.
- Single word, MSB_FIRST=1: 0xA1B2C3D4 with out_ready=1 -> beats A1,B2,C3,D4 on 4 consecutive cycles; last_out=1 only on D4; then valid_out=0 and in_ready=1.
- Back-pressure: same word, out_ready=0 for 3 cycles while B2 is presented -> B2 held stable with valid_out=1 all 3 cycles; sequence completes A1,B2,C3,D4 with no beat lost or duplicated.
- Back-to-back: 0x11223344 then 0x55667788 with valid_in held and out_ready=1 -> 8 beats in 8 consecutive cycles, 11..88. in_ready=1 only in the cycle D4-equivalent 44 transfers. last_out on 44 and 88.
- MSB_FIRST=0: 0xA1B2C3D4 -> beats D4,C3,B2,A1.
- Reset mid-word after beat B2 -> outputs clear. The next word 0x0F0F0F0F starts at beat 0F with count=0. With WORD_UNPACKER_PARITY_EN, parity_out=0 for each 0F beat, and =1 for beat 0x01.
